// File: rtl/arb3_rr_ctrl.sv
// Three-way round-robin arbiter for a single shared datapath resource.
// Holds a registered one-hot grant until done, owner abort or hold timeout.
module arb3_rr_ctrl #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       done,
    output logic [2:0] grant,
    output logic [1:0] owner,
    output logic       busy,
    output logic       any_req,
    output logic       timeout
);

    typedef enum logic {IDLE, OWNED} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ptr;

    logic       owner_req;
    logic       at_max;
    logic       release_now;
    logic [1:0] next_ptr;
    logic [1:0] sel_ptr;
    logic [2:0] win;
    logic [1:0] win_enc;

    // Lowest-priority slot is scanned first so higher-priority hits overwrite it.
    function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] p);
        logic [2:0] g;
        int         idx;
        g = 3'b000;
        for (int k = 2; k >= 0; k--) begin
            idx = (int'(p) + k) % 3;
            if (r[idx]) g = 3'b001 << idx;
        end
        return g;
    endfunction

    assign any_req     = |req;
    assign owner_req   = |(req & grant);
    assign at_max      = (cnt == CNT_W'(MAX_HOLD - 1));
    assign release_now = done || !owner_req || at_max;
    assign next_ptr    = (owner == 2'd2) ? 2'd0 : owner + 2'd1;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sel_ptr = ptr;
        if (state == OWNED) sel_ptr = next_ptr;
        win = pick(req, sel_ptr);
        win_enc = 2'b11;
        case (win)
            3'b001:  win_enc = 2'd0;
            3'b010:  win_enc = 2'd1;
            3'b100:  win_enc = 2'd2;
            default: win_enc = 2'b11;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= 3'b000;
            owner   <= 2'b11;
            busy    <= 1'b0;
            timeout <= 1'b0;
            cnt     <= '0;
            ptr     <= 2'd0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= OWNED;
                        grant <= win;
                        owner <= win_enc;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                OWNED: begin
                    if (release_now) begin
                        ptr     <= next_ptr;
                        cnt     <= '0;
                        // A coincident done or abort wins over the timeout.
                        timeout <= at_max && !done && owner_req;
                        grant   <= win;
                        owner   <= win_enc;
                        busy    <= |win;
                        if (win == 3'b000) state <= IDLE;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb3_rr_ctrl.sv
// Directed bench for arb3_rr_ctrl: one task per scenario, outputs sampled on
// the falling edge and inputs driven right after sampling.
module tb_arb3_rr_ctrl;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic       done;
    logic [2:0] grant;
    logic [1:0] owner;
    logic       busy;
    logic       any_req;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    arb3_rr_ctrl #(.MAX_HOLD(16), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .done    (done),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .any_req (any_req),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        done  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b000 || owner !== 2'b11 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state grant=%b owner=%b busy=%b timeout=%b exp 000/11/0/0",
                     grant, owner, busy, timeout);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_rotation();
        logic [2:0] exp_g [4];
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        test_reset();
        req = 3'b111;
        @(negedge clk);
        n_checks++;
        if (any_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rot_any_req got=%b exp=1", any_req);
        end
        for (int s = 0; s < 4; s++) begin
            if (s > 0) begin
                done = 1'b1;
                @(negedge clk);
                done = 1'b0;
            end
            n_checks++;
            if (grant !== exp_g[s] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rot_step%0d grant=%b busy=%b exp=%b/1", s, grant, busy, exp_g[s]);
            end
        end
        req = 3'b000;
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b000 || owner !== 2'b11 || busy !== 1'b0 || any_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rot_idle grant=%b owner=%b busy=%b any_req=%b exp 000/11/0/0",
                     grant, owner, busy, any_req);
        end
    endtask

    task automatic test_sole_requester();
        test_reset();
        req = 3'b010;
        for (int c = 0; c < 10; c++) begin
            done = (c % 3 == 2);
            @(negedge clk);
            done = 1'b0;
            n_checks++;
            if (grant !== 3'b010 || owner !== 2'd1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL sole_cycle%0d grant=%b owner=%0d busy=%b exp 010/1/1",
                         c, grant, owner, busy);
            end
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        test_reset();
        req = 3'b101;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== 3'b001 || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_cycle%0d grant=%b timeout=%b exp 001/0", k, grant, timeout);
            end
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b100 || owner !== 2'd2 || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_release grant=%b owner=%0d timeout=%b exp 100/2/1",
                     grant, owner, timeout);
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b100 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_pulse_width grant=%b timeout=%b exp 100/0", grant, timeout);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_owner_abort();
        test_reset();
        req = 3'b100;
        @(negedge clk);
        req = 3'b101;
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b100 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL abort_hold grant=%b owner=%0d exp 100/2", grant, owner);
        end
        req = 3'b001;
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b001 || owner !== 2'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_handoff grant=%b owner=%0d timeout=%b exp 001/0/0",
                     grant, owner, timeout);
        end
        req = 3'b000;
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b000 || owner !== 2'b11 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle grant=%b owner=%b busy=%b exp 000/11/0", grant, owner, busy);
        end
    endtask

    task automatic test_reset_mid_grant();
        test_reset();
        req = 3'b100;
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b100) begin
            n_fail++;
            $display("FAIL midrst_pre grant=%b exp=100", grant);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (grant !== 3'b000 || owner !== 2'b11 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async grant=%b owner=%b busy=%b exp 000/11/0", grant, owner, busy);
        end
        req = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b001 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midrst_ptr grant=%b owner=%0d exp 001/0", grant, owner);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    task automatic test_done_corners();
        test_reset();
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_checks++;
        if (grant !== 3'b000 || busy !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_done grant=%b busy=%b timeout=%b exp 000/0/0", grant, busy, timeout);
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_done_after grant=%b exp=000", grant);
        end
        req = 3'b011;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== 3'b001) begin
                n_fail++;
                $display("FAIL coinc_hold%0d grant=%b exp=001", k, grant);
            end
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        n_checks++;
        if (grant !== 3'b010 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_release grant=%b timeout=%b exp 010/0", grant, timeout);
        end
        @(negedge clk);
        n_checks++;
        if (grant !== 3'b010 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL coinc_after grant=%b timeout=%b exp 010/0", grant, timeout);
        end
        req = 3'b000;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 3'b000;
        done  = 1'b0;
        test_reset();
        test_rotation();
        test_sole_requester();
        test_timeout();
        test_owner_abort();
        test_reset_mid_grant();
        test_done_corners();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
